// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler output packer.
//   CLOG2          : ceiling log2, used for counter widths
//   state_e        : packer FSM encoding
//   LANE_W/BPW/KEEP_W : lane width, beats per word and byte-enable width
//                    for the default pixel/word geometry
package scaler_pkg;

   function automatic int CLOG2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int DEF_PIXEL_BITWIDTH = 8;
   localparam int DEF_PIXEL_NUM      = 1;
   localparam int DEF_OUT_BITWIDTH   = 64;

   localparam int LANE_W = DEF_PIXEL_BITWIDTH * DEF_PIXEL_NUM;
   localparam int BPW    = DEF_OUT_BITWIDTH / LANE_W;
   localparam int KEEP_W = DEF_OUT_BITWIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_RUN      = 2'd2,
      ST_FLUSH    = 2'd3
   } state_e;

endpackage

// File: rtl/scaler_vout_pack_if.sv
// Stream bundle around the packer: scaled pixel input (s_axis_*) and
// packed word output (m_axis_*).
//   slave  : packer side (consumes pixels, produces words)
//   master : environment side (produces pixels, consumes words)
interface scaler_vout_pack_if
   import scaler_pkg::*;
#(
   parameter int PIX_W = DEF_PIXEL_BITWIDTH * DEF_PIXEL_NUM,
   parameter int OUT_W = DEF_OUT_BITWIDTH
);
   logic                 s_axis_ready;
   logic                 s_axis_valid;
   logic [PIX_W-1:0]     s_axis_pixel;
   logic                 s_axis_sof;
   logic                 s_axis_eol;
   logic                 m_axis_tready;
   logic                 m_axis_tvalid;
   logic [OUT_W-1:0]     m_axis_tdata;
   logic [OUT_W/8-1:0]   m_axis_tkeep;
   logic                 m_axis_tuser;
   logic                 m_axis_tlast;

   modport slave (
      output s_axis_ready,
      input  s_axis_valid, s_axis_pixel, s_axis_sof, s_axis_eol,
      input  m_axis_tready,
      output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast
   );

   modport master (
      input  s_axis_ready,
      output s_axis_valid, s_axis_pixel, s_axis_sof, s_axis_eol,
      output m_axis_tready,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast
   );

endinterface

// File: rtl/scaler_pack_lane_acc.sv
// Lane accumulator: collects beats little-endian into one output word.
//   clk, rst_n    : clock, synchronous active-low reset
//   clr_i         : drop any partial word
//   beat_we_i     : beat accepted, write beat_data_i into lane[idx]
//   force_emit_i  : close the word early (line end)
//   word_emit_o   : word complete on this beat
//   word_data_o   : word including the current beat, unwritten lanes zero
//   word_keep_o   : byte enables of the written lanes
module scaler_pack_lane_acc
   import scaler_pkg::*;
#(
   parameter int LANE_BITS = LANE_W,
   parameter int BEATS     = BPW,
   parameter int OUT_BITS  = DEF_OUT_BITWIDTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  beat_we_i,
   input  logic [LANE_BITS-1:0]  beat_data_i,
   input  logic                  force_emit_i,
   output logic                  word_emit_o,
   output logic [OUT_BITS-1:0]   word_data_o,
   output logic [OUT_BITS/8-1:0] word_keep_o
);
   localparam int LANE_KEEP = LANE_BITS / 8;
   localparam int IDX_W     = (BEATS > 1) ? CLOG2(BEATS) : 1;

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [OUT_BITS-1:0]   acc_q, acc_d;
   logic [OUT_BITS/8-1:0] keep_q, keep_d;

   // Current word with the incoming beat merged into its lane.
   always_comb begin
      word_data_o = acc_q;
      word_keep_o = keep_q;
      for (int l = 0; l < BEATS; l++) begin
         if (idx_q == IDX_W'(l)) begin
            word_data_o[l*LANE_BITS +: LANE_BITS] = beat_data_i;
            word_keep_o[l*LANE_KEEP +: LANE_KEEP] = '1;
         end
      end
      word_emit_o = beat_we_i & ((idx_q == IDX_W'(BEATS-1)) | force_emit_i);
   end

   // After an emit the accumulator restarts empty so a short word is zero padded.
   always_comb begin
      idx_d  = idx_q;
      acc_d  = acc_q;
      keep_d = keep_q;
      if (clr_i) begin
         idx_d  = '0;
         acc_d  = '0;
         keep_d = '0;
      end else if (beat_we_i) begin
         if (word_emit_o) begin
            idx_d  = '0;
            acc_d  = '0;
            keep_d = '0;
         end else begin
            idx_d  = idx_q + IDX_W'(1);
            acc_d  = word_data_o;
            keep_d = word_keep_o;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q  <= '0;
         acc_q  <= '0;
         keep_q <= '0;
      end else begin
         idx_q  <= idx_d;
         acc_q  <= acc_d;
         keep_q <= keep_d;
      end
   end

endmodule

// File: rtl/scaler_vout_pack.sv
// Scaler output packer: packs the scaled pixel stream into frame-buffer
// words with keep/tuser/tlast and checks frame geometry.
//   m_clk, m_rst_n            : clock, synchronous active-low reset
//   m_start                   : arm for one frame (IDLE only)
//   arg_img_des_h/_v          : beats per line / lines per frame, 0 means 1
//   axis (slave)              : pixel input and packed word output streams
//   m_pack_done               : one-cycle pulse after the tlast word handshake
//   err_sof                   : sticky, beats discarded before sof or sof in frame
//   err_eol                   : sticky, eol disagreed with the programmed width
//
// state    | meaning
// IDLE     | not armed, input stalled
// WAIT_SOF | armed, non-sof beats are dropped
// RUN      | packing beats of the frame
// FLUSH    | tlast word waiting for its handshake
module scaler_vout_pack
   import scaler_pkg::*;
#(
   parameter int PIXEL_BITWIDTH = DEF_PIXEL_BITWIDTH,
   parameter int PIXEL_NUM      = DEF_PIXEL_NUM,
   parameter int OUT_BITWIDTH   = DEF_OUT_BITWIDTH,
   parameter int IMG_H_MAX      = 1920,
   parameter int IMG_V_MAX      = 1080,
   parameter int IMG_H_BITWIDTH = CLOG2(IMG_H_MAX),
   parameter int IMG_V_BITWIDTH = CLOG2(IMG_V_MAX)
)(
   input  logic                      m_clk,
   input  logic                      m_rst_n,
   input  logic                      m_start,
   input  logic [IMG_H_BITWIDTH-1:0] arg_img_des_h,
   input  logic [IMG_V_BITWIDTH-1:0] arg_img_des_v,
   scaler_vout_pack_if.slave         axis,
   output logic                      m_pack_done,
   output logic                      err_sof,
   output logic                      err_eol
);
   localparam int LANE_BITS = PIXEL_BITWIDTH * PIXEL_NUM;
   localparam int BEATS     = OUT_BITWIDTH / LANE_BITS;
   localparam int KEEP_BITS = OUT_BITWIDTH / 8;

   state_e                    state_q, state_d;
   logic [IMG_H_BITWIDTH-1:0] h_q, h_d, col_q, col_d;
   logic [IMG_V_BITWIDTH-1:0] v_q, v_d, row_q, row_d;
   logic                      first_q, first_d;
   logic                      err_sof_q, err_sof_d, err_eol_q, err_eol_d;
   logic                      done_q, done_d;
   logic                      tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
   logic [OUT_BITWIDTH-1:0]   tdata_q, tdata_d;
   logic [KEEP_BITS-1:0]      tkeep_q, tkeep_d;

   logic                      s_ready, beat_acc, beat_we, sof_take;
   logic                      h_end, line_end, frame_end;
   logic                      word_emit;
   logic [OUT_BITWIDTH-1:0]   word_data;
   logic [KEEP_BITS-1:0]      word_keep;

   // Every accepted beat is gated by output-register space, so a word can
   // always be registered on the beat that completes it.
   assign s_ready   = ((state_q == ST_WAIT_SOF) | (state_q == ST_RUN)) &
                      (!tvalid_q | axis.m_axis_tready);
   assign beat_acc  = axis.s_axis_valid & s_ready;
   assign sof_take  = beat_acc & (state_q == ST_WAIT_SOF) & axis.s_axis_sof;
   assign beat_we   = sof_take | (beat_acc & (state_q == ST_RUN));
   assign h_end     = (col_q == h_q - IMG_H_BITWIDTH'(1));
   assign line_end  = beat_we & (axis.s_axis_eol | h_end);
   assign frame_end = line_end & (row_q == v_q - IMG_V_BITWIDTH'(1));

   scaler_pack_lane_acc #(
      .LANE_BITS (LANE_BITS),
      .BEATS     (BEATS),
      .OUT_BITS  (OUT_BITWIDTH)
   ) u_lane_acc (
      .clk          (m_clk),
      .rst_n        (m_rst_n),
      .clr_i        (state_q == ST_IDLE),
      .beat_we_i    (beat_we),
      .beat_data_i  (axis.s_axis_pixel),
      .force_emit_i (line_end),
      .word_emit_o  (word_emit),
      .word_data_o  (word_data),
      .word_keep_o  (word_keep)
   );

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      v_d       = v_q;
      col_d     = col_q;
      row_d     = row_q;
      first_d   = first_q;
      err_sof_d = err_sof_q;
      err_eol_d = err_eol_q;
      done_d    = 1'b0;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      tkeep_d   = tkeep_q;
      tuser_d   = tuser_q;
      tlast_d   = tlast_q;

      case (state_q)
         ST_IDLE: begin
            if (m_start) begin
               h_d       = (arg_img_des_h == '0) ? IMG_H_BITWIDTH'(1) : arg_img_des_h;
               v_d       = (arg_img_des_v == '0) ? IMG_V_BITWIDTH'(1) : arg_img_des_v;
               col_d     = '0;
               row_d     = '0;
               first_d   = 1'b0;
               err_sof_d = 1'b0;
               err_eol_d = 1'b0;
               state_d   = ST_WAIT_SOF;
            end
         end
         ST_WAIT_SOF: begin
            if (beat_acc) begin
               if (axis.s_axis_sof) state_d   = ST_RUN;
               else                 err_sof_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (beat_acc && axis.s_axis_sof) err_sof_d = 1'b1;
         end
         ST_FLUSH: begin
            if (tvalid_q && axis.m_axis_tready && tlast_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The line closes on whichever of eol / programmed width comes first.
      if (beat_we) begin
         if (axis.s_axis_eol != h_end) err_eol_d = 1'b1;
         if (line_end) begin
            col_d = '0;
            row_d = row_q + IMG_V_BITWIDTH'(1);
         end else begin
            col_d = col_q + IMG_H_BITWIDTH'(1);
         end
         if (frame_end) state_d = ST_FLUSH;
      end

      if (word_emit) begin
         tvalid_d = 1'b1;
         tdata_d  = word_data;
         tkeep_d  = word_keep;
         tuser_d  = first_q | sof_take;
         tlast_d  = frame_end;
         first_d  = 1'b0;
      end else begin
         if (axis.m_axis_tready) tvalid_d = 1'b0;
         if (sof_take)           first_d  = 1'b1;
      end
   end

   always_ff @(posedge m_clk) begin
      if (!m_rst_n) begin
         state_q   <= ST_IDLE;
         h_q       <= '0;
         v_q       <= '0;
         col_q     <= '0;
         row_q     <= '0;
         first_q   <= 1'b0;
         err_sof_q <= 1'b0;
         err_eol_q <= 1'b0;
         done_q    <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tkeep_q   <= '0;
         tuser_q   <= 1'b0;
         tlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         v_q       <= v_d;
         col_q     <= col_d;
         row_q     <= row_d;
         first_q   <= first_d;
         err_sof_q <= err_sof_d;
         err_eol_q <= err_eol_d;
         done_q    <= done_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tkeep_q   <= tkeep_d;
         tuser_q   <= tuser_d;
         tlast_q   <= tlast_d;
      end
   end

   assign axis.s_axis_ready  = s_ready;
   assign axis.m_axis_tvalid = tvalid_q;
   assign axis.m_axis_tdata  = tdata_q;
   assign axis.m_axis_tkeep  = tkeep_q;
   assign axis.m_axis_tuser  = tuser_q;
   assign axis.m_axis_tlast  = tlast_q;
   assign m_pack_done        = done_q;
   assign err_sof            = err_sof_q;
   assign err_eol            = err_eol_q;

endmodule

// File: tb/tb_scaler_vout_pack.sv
module tb_scaler_vout_pack;
   import scaler_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [10:0] arg_h, arg_v;
   logic        done, e_sof, e_eol;

   always #5 clk = ~clk;

   scaler_vout_pack_if #(.PIX_W(8), .OUT_W(64)) axis ();

   scaler_vout_pack dut (
      .m_clk         (clk),
      .m_rst_n       (rst_n),
      .m_start       (start),
      .arg_img_des_h (arg_h),
      .arg_img_des_v (arg_v),
      .axis          (axis),
      .m_pack_done   (done),
      .err_sof       (e_sof),
      .err_eol       (e_eol)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        user;
      logic        last;
   } word_t;

   word_t exp_q[$];
   int    n_vec = 0;
   int    n_bad = 0;
   int    done_cnt = 0;
   bit    bp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // tready: constant 1, or 1 cycle on / 2 cycles off when bp_en
   initial begin
      int cnt;
      cnt = 0;
      axis.m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cnt++;
         axis.m_axis_tready = bp_en ? (cnt % 3 == 0) : 1'b1;
      end
   end

   // scoreboard monitor
   initial begin
      bit          stalled;
      bit          expect_done;
      logic [63:0] held;
      word_t       e;
      stalled = 0;
      expect_done = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (expect_done) begin
               check("done_pulse", 64'(done), 64'd1);
               if (done) done_cnt++;
               expect_done = 0;
            end else if (done) begin
               check("done_spurious", 64'(done), 64'd0);
            end
            if (stalled) begin
               check("stall_tvalid", 64'(axis.m_axis_tvalid), 64'd1);
               check("stall_tdata", axis.m_axis_tdata, held);
            end
            stalled = 0;
            if (axis.m_axis_tvalid && !axis.m_axis_tready) begin
               check("ready_gated", 64'(axis.s_axis_ready), 64'd0);
               stalled = 1;
               held = axis.m_axis_tdata;
            end
            if (axis.m_axis_tvalid && axis.m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  check("extra_word", axis.m_axis_tdata, 64'hDEAD_DEAD_DEAD_DEAD ^ axis.m_axis_tdata ^ 64'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("tdata", axis.m_axis_tdata, e.data);
                  check("tkeep", 64'(axis.m_axis_tkeep), 64'(e.keep));
                  check("tuser", 64'(axis.m_axis_tuser), 64'(e.user));
                  check("tlast", 64'(axis.m_axis_tlast), 64'(e.last));
                  if (e.last) expect_done = 1;
               end
            end
         end
      end
   end

   task automatic push(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
      word_t w;
      w.data = d; w.keep = k; w.user = u; w.last = l;
      exp_q.push_back(w);
   endtask

   task automatic push_base();
      push(64'h0706050403020100, 8'hFF, 1'b1, 1'b0);
      push(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
      push(64'h1716151413121110, 8'hFF, 1'b0, 1'b0);
      push(64'h1F1E1D1C1B1A1918, 8'hFF, 1'b0, 1'b1);
   endtask

   task automatic send_beat(input logic [7:0] pix, input bit sof, input bit eol);
      bit r;
      int guard;
      r = 0;
      guard = 0;
      axis.s_axis_valid = 1'b1;
      axis.s_axis_pixel = pix;
      axis.s_axis_sof   = sof;
      axis.s_axis_eol   = eol;
      while (!r) begin
         @(negedge clk);
         r = axis.s_axis_ready;
         @(posedge clk);
         #1;
         if (!r) begin
            guard++;
            if (guard >= 200) begin
               check("beat_timeout", 64'd0, 64'd1);
               r = 1;
            end
         end
      end
      axis.s_axis_valid = 1'b0;
      axis.s_axis_sof   = 1'b0;
      axis.s_axis_eol   = 1'b0;
   endtask

   task automatic send_line(input logic [7:0] base, input int n, input bit sof);
      for (int i = 0; i < n; i++)
         send_beat(base + 8'(i), sof && (i == 0), i == n - 1);
   endtask

   task automatic start_frame(input logic [10:0] h, input logic [10:0] v);
      @(posedge clk);
      #1;
      start = 1'b1;
      arg_h = h;
      arg_v = v;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_base();
      send_line(8'h00, 16, 1'b1);
      send_line(8'h10, 16, 1'b0);
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (done_cnt < target && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("frame_done", 64'(done_cnt), 64'(target));
      repeat (3) @(posedge clk);
      #1;
      check("words_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      arg_h = '0;
      arg_v = '0;
      axis.s_axis_valid = 1'b0;
      axis.s_axis_pixel = '0;
      axis.s_axis_sof   = 1'b0;
      axis.s_axis_eol   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
      check("rst_tdata", axis.m_axis_tdata, 64'd0);
      check("rst_tkeep", 64'(axis.m_axis_tkeep), 64'd0);
      check("rst_tuser_tlast", 64'({axis.m_axis_tuser, axis.m_axis_tlast}), 64'd0);
      check("rst_ready", 64'(axis.s_axis_ready), 64'd0);
      check("rst_done_err", 64'({done, e_sof, e_eol}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // base frame
      push_base();
      start_frame(11'd16, 11'd2);
      send_base();
      wait_done(1);
      check("base_err", 64'({e_sof, e_eol}), 64'd0);

      // partial last word
      push(64'h0706050403020100, 8'hFF, 1'b1, 1'b0);
      push(64'h000000000B0A0908, 8'h0F, 1'b0, 1'b1);
      start_frame(11'd12, 11'd1);
      send_line(8'h00, 12, 1'b1);
      wait_done(2);
      check("partial_err", 64'({e_sof, e_eol}), 64'd0);

      // backpressure
      bp_en = 1'b1;
      push_base();
      start_frame(11'd16, 11'd2);
      send_base();
      wait_done(3);
      bp_en = 1'b0;

      // missing sof
      push_base();
      start_frame(11'd16, 11'd2);
      for (int i = 0; i < 3; i++) send_beat(8'hAA, 1'b0, 1'b0);
      send_base();
      wait_done(4);
      check("nosof_err_sof", 64'(e_sof), 64'd1);
      check("nosof_err_eol", 64'(e_eol), 64'd0);

      // short line: eol on beat 10 of line 0
      push(64'h0706050403020100, 8'hFF, 1'b1, 1'b0);
      push(64'h0000000000000908, 8'h03, 1'b0, 1'b0);
      push(64'h1716151413121110, 8'hFF, 1'b0, 1'b0);
      push(64'h1F1E1D1C1B1A1918, 8'hFF, 1'b0, 1'b1);
      start_frame(11'd16, 11'd2);
      send_line(8'h00, 10, 1'b1);
      send_line(8'h10, 16, 1'b0);
      wait_done(5);
      check("short_err_eol", 64'(e_eol), 64'd1);
      check("short_err_sof", 64'(e_sof), 64'd0);

      // reset mid-frame
      start_frame(11'd16, 11'd2);
      send_beat(8'h00, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) send_beat(8'(i), 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_outputs", 64'({axis.m_axis_tvalid, axis.m_axis_tuser, axis.m_axis_tlast,
                                   axis.s_axis_ready, done, e_sof, e_eol}), 64'd0);
      check("midrst_tdata_tkeep", axis.m_axis_tdata | 64'(axis.m_axis_tkeep), 64'd0);
      check("midrst_state", 64'(dut.state_q), 64'(ST_IDLE));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_base();
      start_frame(11'd16, 11'd2);
      send_base();
      wait_done(6);
      check("midrst_err", 64'({e_sof, e_eol}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/scaler_vout_pack.md
Name: scaler_vout_pack

Overview:
- Sits directly downstream of the scaler output stage, in the m_clk domain.
- Consumes the scaled pixel stream (valid/ready, sof, eol) and packs pixels little-endian into OUT_BITWIDTH-wide words for the frame-buffer write DMA.
- Generates byte keep, tuser (first word of frame) and tlast (last word of frame).
- Checks frame geometry against the programmed destination size and reports frame completion.

Parameters:
- PIXEL_BITWIDTH, 8, bits per pixel.
- PIXEL_NUM, 1, pixels per input beat.
- OUT_BITWIDTH, 64, output word width. OUT_BITWIDTH/(PIXEL_BITWIDTH*PIXEL_NUM) = BPW beats per word; BPW must be a power of 2 and ≥ 1.
- IMG_H_MAX, 1920, maximum destination width in beats.
- IMG_V_MAX, 1080, maximum destination height in lines.
- IMG_H_BITWIDTH, CLOG2(IMG_H_MAX), width of the h argument.
- IMG_V_BITWIDTH, CLOG2(IMG_V_MAX), width of the v argument.

Ports:
- m_clk  in  1  the single clock.
- m_rst_n  in  1  synchronous, active-low reset.
- m_start  in  1  single-cycle pulse that arms the block for one frame.
- arg_img_des_h  in  IMG_H_BITWIDTH  beats per line; latched at m_start.
- arg_img_des_v  in  IMG_V_BITWIDTH  lines per frame; latched at m_start.
- s_axis_ready  out  1  input ready.
- s_axis_valid  in  1  input valid.
- s_axis_pixel  in  PIXEL_BITWIDTH*PIXEL_NUM  input pixels.
- s_axis_sof  in  1  first beat of frame.
- s_axis_eol  in  1  last beat of line.
- m_axis_tready  in  1  output ready.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tdata  out  OUT_BITWIDTH  packed word.
- m_axis_tkeep  out  OUT_BITWIDTH/8  byte enables.
- m_axis_tuser  out  1  first word of frame.
- m_axis_tlast  out  1  last word of frame.
- m_pack_done  out  1  one-cycle pulse when the frame is fully delivered.
- err_sof  out  1  sticky: beats were discarded before sof.
- err_eol  out  1  sticky: line length did not match h.

Behaviour:
- Reset (m_rst_n = 0 at a clock edge):
  - State goes to IDLE.
  - Accumulator, beat/line counters and lane index clear.
  - All outputs go to 0, including s_axis_ready, tvalid, tdata, tkeep, tuser, tlast, done and both error flags.
  - Reset in mid-frame abandons the frame with no flush.
- FSM IDLE -> WAIT_SOF -> RUN -> FLUSH -> IDLE.
- IDLE:
  - s_axis_ready = 0.
  - On m_start: latch h and v, clear err_sof and err_eol, go to WAIT_SOF.
  - m_start outside IDLE is ignored.
- WAIT_SOF:
  - s_axis_ready = 1.
  - Beats without sof are accepted and discarded, and err_sof is set.
  - A beat with sof is accepted as pixel 0 of line 0; go to RUN.
- RUN:
  - Accepted beat = s_axis_valid & s_axis_ready.
  - Each accepted beat is written into lane[idx]; lane 0 occupies tdata LSBs.
  - idx increments, the beat counter col increments and the keep bits for that lane are set.
- Word emit condition: the accepted beat fills lane BPW-1, or the accepted beat is the line end. The emitted word is registered into the output stage on the same edge.
  - Output appears one cycle after the accepting edge.
  - Keep covers only the lanes written; a partial word is padded with zero data.
  - idx resets to 0 after every emit.
- Line end is s_axis_eol, or col = h-1 without eol.
  - On line end: col returns to 0 and row increments.
  - If eol and (col = h-1) disagree, err_eol is set. The line still closes at whichever event occurs first.
- The word that carries line end with row = v-1 has tlast = 1; go to FLUSH.
- tuser = 1 only on the first word emitted after sof.
- Handshake:
  - The output register holds its values while tvalid & !tready.
  - s_axis_ready = (state is WAIT_SOF or RUN) & (!m_axis_tvalid | m_axis_tready). This gives full throughput under continuous tready.
  - Beats that do not complete a word are also gated by this term, so the input never overruns the output register.
- FLUSH:
  - s_axis_ready = 0.
  - When the tlast word handshakes, pulse m_pack_done for 1 cycle and go to IDLE.
- Simultaneous events:
  - sof arriving in RUN is treated as data and sets err_sof.
  - m_start during FLUSH is ignored.
- Width rules:
  - Counters are sized IMG_H_BITWIDTH and IMG_V_BITWIDTH.
  - h = 0 or v = 0 is treated as 1.

Decomposition:
- A shared package scaler_pkg holds:
  - CLOG2;
  - the FSM state encoding;
  - derived constants BPW, LANE_W and KEEP_W.
- One sub-module, scaler_pack_lane_acc, holds the lane accumulator, keep generation and idx counter, and emits a word-complete strobe.
- The top level holds the FSM, line and frame counters, error flags and the output register.

Test Plan:
- Base frame, with PIXEL_NUM = 1, 8-bit pixels, 64-bit output, h = 16, v = 2, tready always 1, pixels 0x00..0x1F:
  - exactly 4 words;
  - word0 = 0x0706050403020100 with tuser = 1 and keep = 0xFF;
  - word3 has tlast = 1;
  - m_pack_done pulses once, one cycle after the word3 handshake;
  - no error flags.
- Partial last word, h = 12, v = 1:
  - word0 keep = 0xFF;
  - word1 keep = 0x0F with upper data bytes 0;
  - word1 has tlast = 1.
- Backpressure, base frame with tready toggling 1 cycle on, 2 cycles off:
  - tdata and tvalid stay stable while stalled;
  - s_axis_ready drops whenever tvalid & !tready;
  - the word sequence is identical to the base frame.
- Missing sof: 3 beats sent before sof, then the base frame:
  - err_sof = 1;
  - output identical to the base frame.
- Short line, h = 16 but eol on beat 10 of line 0:
  - err_eol = 1;
  - line 0 emits a word with keep 0xFF, then a word with keep 0x03;
  - the frame still completes with tlast.
- Reset mid-frame: assert m_rst_n = 0 after 5 beats:
  - next cycle all outputs are 0 and state is IDLE;
  - a new m_start plus base frame produces the correct 4 words.
